alarm_sequencer: RTL

Arm/disarm sequencer for the IR beam-break alarm. It debounces the IR sensor, edge-detects the arm and disarm switches, and times the exit delay, entry delay and alarm periods. It drives the alarm-active flag that enables the buzzer tone path, the armed and disarmed status flags, and the state code and countdown for the 7-segment display.

---
 rtl/alarm_sequencer.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - IR beam-break alarm arm/disarm sequencer
//
// Purpose: synchronizes the IR sensor and the arm/disarm switches, debounces the
// beam-break, and sequences DISARMED -> EXIT_DELAY -> ARMED -> ENTRY_DELAY -> ALARM
// with tick-based countdowns.
//
// Ports:
//   clk            global clock
//   rst_n          synchronous active-low reset
//   ir_sensor      async, 1 = beam broken
//   arm_sw         async arm switch, rising edge acts
//   disarm_sw      async disarm switch, rising edge acts
//   system_armed   high in ARMED, ENTRY_DELAY, ALARM
//   disarmed_state high in DISARMED
//   alarm_active   high in ALARM (buzzer enable)
//   chime          delay-warning beep
//   display_input  00 DISARMED, 01 EXIT/ENTRY delay, 10 ARMED, 11 ALARM
//   countdown      remaining ticks of the current timed state, else 0
//   arm_refused    one-cycle pulse when an arm request is rejected

module alarm_sequencer #(
   parameter int TICK_DIV    = 1000,
   parameter int EXIT_TICKS  = 10,
   parameter int ENTRY_TICKS = 5,
   parameter int ALARM_TICKS = 30,
   parameter int DEBOUNCE    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ir_sensor,
   input  logic       arm_sw,
   input  logic       disarm_sw,
   output logic       system_armed,
   output logic       disarmed_state,
   output logic       alarm_active,
   output logic       chime,
   output logic [1:0] display_input,
   output logic [7:0] countdown,
   output logic       arm_refused
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam logic [PW-1:0] LP_TICK_MAX = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] LP_HALF     = PW'(TICK_DIV / 2);
   localparam logic [DW-1:0] LP_DB_MAX   = DW'(DEBOUNCE - 1);
   localparam logic [7:0]    LP_EXIT     = 8'(EXIT_TICKS);
   localparam logic [7:0]    LP_ENTRY    = 8'(ENTRY_TICKS);
   localparam logic [7:0]    LP_ALARM    = 8'(ALARM_TICKS);

   typedef enum logic [2:0] {
      ST_DISARMED,
      ST_EXIT_DELAY,
      ST_ARMED,
      ST_ENTRY_DELAY,
      ST_ALARM
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [7:0]      r_countdown, w_countdown_nxt;
   logic [PW-1:0]   r_presc, w_presc_nxt;
   logic            r_arm_refused, w_arm_refused_nxt;

   logic            r_ir_meta, r_ir_sync;
   logic            r_arm_meta, r_arm_sync, r_arm_prev;
   logic            r_dis_meta, r_dis_sync, r_dis_prev;
   logic [DW-1:0]   r_db_cnt;

   logic            w_arm_edge, w_dis_edge, w_breach, w_tick;

   // Input synchronizers, switch edge history and the breach debounce counter.
   // The counter saturates at DEBOUNCE-1; breach is the saturated count while the
   // synchronized sample is still high, so it drops on the first low sample.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ir_meta  <= 1'b0;
         r_ir_sync  <= 1'b0;
         r_arm_meta <= 1'b0;
         r_arm_sync <= 1'b0;
         r_arm_prev <= 1'b0;
         r_dis_meta <= 1'b0;
         r_dis_sync <= 1'b0;
         r_dis_prev <= 1'b0;
         r_db_cnt   <= '0;
      end else begin
         r_ir_meta  <= ir_sensor;
         r_ir_sync  <= r_ir_meta;
         r_arm_meta <= arm_sw;
         r_arm_sync <= r_arm_meta;
         r_arm_prev <= r_arm_sync;
         r_dis_meta <= disarm_sw;
         r_dis_sync <= r_dis_meta;
         r_dis_prev <= r_dis_sync;
         if (!r_ir_sync) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt != LP_DB_MAX) begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   assign w_arm_edge = r_arm_sync & ~r_arm_prev;
   assign w_dis_edge = r_dis_sync & ~r_dis_prev;
   assign w_breach   = r_ir_sync && (r_db_cnt == LP_DB_MAX);
   assign w_tick     = (r_presc == LP_TICK_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_DISARMED;
         r_countdown   <= 8'd0;
         r_presc       <= '0;
         r_arm_refused <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_countdown   <= w_countdown_nxt;
         r_presc       <= w_presc_nxt;
         r_arm_refused <= w_arm_refused_nxt;
      end
   end

   // Every state change restarts the prescaler so each timed state lasts exactly
   // ticks * TICK_DIV cycles. An ALARM reload happens on a tick, where the
   // prescaler wraps to 0 anyway.
   always_comb begin
      w_state_nxt       = r_state;
      w_countdown_nxt   = r_countdown;
      w_presc_nxt       = w_tick ? '0 : r_presc + 1'b1;
      w_arm_refused_nxt = 1'b0;

      if (w_dis_edge) begin
         w_state_nxt     = ST_DISARMED;
         w_countdown_nxt = 8'd0;
         w_presc_nxt     = '0;
      end else begin
         case (r_state)
            ST_DISARMED: begin
               if (w_arm_edge) begin
                  if (w_breach) begin
                     w_arm_refused_nxt = 1'b1;
                  end else begin
                     w_state_nxt     = ST_EXIT_DELAY;
                     w_countdown_nxt = LP_EXIT;
                     w_presc_nxt     = '0;
                  end
               end
            end
            ST_EXIT_DELAY: begin
               if (w_tick) begin
                  if (r_countdown == 8'd1) begin
                     w_state_nxt     = ST_ARMED;
                     w_countdown_nxt = 8'd0;
                     w_presc_nxt     = '0;
                  end else if (r_countdown != 8'd0) begin
                     w_countdown_nxt = r_countdown - 8'd1;
                  end
               end
            end
            ST_ARMED: begin
               if (w_breach) begin
                  w_state_nxt     = ST_ENTRY_DELAY;
                  w_countdown_nxt = LP_ENTRY;
                  w_presc_nxt     = '0;
               end
            end
            ST_ENTRY_DELAY: begin
               if (w_tick) begin
                  if (r_countdown == 8'd1) begin
                     w_state_nxt     = ST_ALARM;
                     w_countdown_nxt = LP_ALARM;
                     w_presc_nxt     = '0;
                  end else if (r_countdown != 8'd0) begin
                     w_countdown_nxt = r_countdown - 8'd1;
                  end
               end
            end
            ST_ALARM: begin
               if (w_tick) begin
                  if (r_countdown == 8'd1) begin
                     if (w_breach) begin
                        w_countdown_nxt = LP_ALARM;
                     end else begin
                        w_state_nxt     = ST_ARMED;
                        w_countdown_nxt = 8'd0;
                        w_presc_nxt     = '0;
                     end
                  end else if (r_countdown != 8'd0) begin
                     w_countdown_nxt = r_countdown - 8'd1;
                  end
               end
            end
            default: begin
               w_state_nxt     = ST_DISARMED;
               w_countdown_nxt = 8'd0;
               w_presc_nxt     = '0;
            end
         endcase
      end
   end

   // Moore decode from registers only.
   always_comb begin
      system_armed   = 1'b0;
      disarmed_state = 1'b0;
      alarm_active   = 1'b0;
      chime          = 1'b0;
      display_input  = 2'b00;
      case (r_state)
         ST_DISARMED: begin
            disarmed_state = 1'b1;
         end
         ST_EXIT_DELAY: begin
            display_input = 2'b01;
            chime         = (r_presc < LP_HALF);
         end
         ST_ARMED: begin
            system_armed  = 1'b1;
            display_input = 2'b10;
         end
         ST_ENTRY_DELAY: begin
            system_armed  = 1'b1;
            display_input = 2'b01;
            chime         = (r_presc < LP_HALF);
         end
         ST_ALARM: begin
            system_armed  = 1'b1;
            alarm_active  = 1'b1;
            display_input = 2'b11;
         end
         default: begin
            disarmed_state = 1'b1;
         end
      endcase
   end

   assign countdown   = r_countdown;
   assign arm_refused = r_arm_refused;

endmodule
